// File: rtl/complement_decode_4bits_pkg.sv
// Shared constants and types for the complement-to-sign-magnitude decoder.
package complement_decode_4bits_pkg;

   // Operand and result width.
   localparam int WIDTH = 4;

   // Index of the last magnitude bit processed in CONV.
   localparam logic [1:0] LAST_IDX = 2'd2;

   // Control FSM encodings.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Carry preloaded into the serial adder at start.
   // Two's complement adds one to the inverted magnitude; one's complement adds nothing.
   function automatic logic carry_in(input logic neg, input logic twos);
      carry_in = neg & twos;
   endfunction

endpackage

// File: rtl/complement_decode_4bits_if.sv
// Request/result bundle for complement_decode_4bits.
// master drives the request, slave is the decoder.
interface complement_decode_4bits_if;
   import complement_decode_4bits_pkg::*;

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] sum;
   logic             busy;
   logic             finish;
   logic             ovf;

   modport master (
      output start,
      output a,
      input  sum,
      input  busy,
      input  finish,
      input  ovf
   );

   modport slave (
      input  start,
      input  a,
      output sum,
      output busy,
      output finish,
      output ovf
   );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder used as the serial add cell of the decoder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum,
   output logic co
);

   // Plain combinational sum and carry.
   always_comb begin
      sum = a ^ b ^ ci;
      co  = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/complement_decode_4bits.sv
// Serial complement-coded to sign-magnitude decoder.
// Converts one magnitude bit per cycle (bit 0..2) through a single full adder
// with a registered carry. Build option: define COMPLEMENT2_EN for a two's
// complement operand (carry-in 1, overflow reported); leave it undefined for
// one's complement (carry-in 0, overflow tied low).
module complement_decode_4bits
   import complement_decode_4bits_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   complement_decode_4bits_if.slave       bus
);

`ifdef COMPLEMENT2_EN
   localparam logic TWOS = 1'b1;
`else
   localparam logic TWOS = 1'b0;
`endif

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [1:0]       r_idx;
   logic             r_c;
   logic [2:0]       r_mag;
   logic [WIDTH-1:0] r_sum;
   logic             r_ovf;

   logic             w_neg;
   logic             w_fa_a;
   logic             w_fa_sum;
   logic             w_fa_co;
   logic             w_last;

   assign w_neg  = r_a[WIDTH-1];
   assign w_last = (r_idx == LAST_IDX);

   // Negative operands add the carry to the inverted bit; positive ones pass
   // the bit straight through (carry is preloaded to zero for them).
   assign w_fa_a = w_neg ? ~r_a[r_idx] : r_a[r_idx];

   full_adder u_fa (
      .a   (w_fa_a),
      .b   (1'b0),
      .ci  (r_c),
      .sum (w_fa_sum),
      .co  (w_fa_co)
   );

   // State register; reset forces IDLE immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: start restarts from any state, CONV ends on the last bit,
   // IDLE and DONE hold.
   always_comb begin
      w_next_state = r_state;
      if (bus.start) begin
         w_next_state = CONV;
      end else begin
         case (r_state)
            CONV:    if (w_last) w_next_state = DONE;
            IDLE:    w_next_state = IDLE;
            DONE:    w_next_state = DONE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // Status outputs decoded from state.
   always_comb begin
      bus.busy   = 1'b0;
      bus.finish = 1'b0;
      case (r_state)
         CONV:    bus.busy   = 1'b1;
         DONE:    bus.finish = 1'b1;
         default: begin
            bus.busy   = 1'b0;
            bus.finish = 1'b0;
         end
      endcase
   end

   // Datapath: capture operand at start, then shift one magnitude bit per
   // CONV cycle; the last bit loads the result and overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_idx <= 2'd0;
         r_c   <= 1'b0;
         r_mag <= 3'b000;
         r_sum <= '0;
         r_ovf <= 1'b0;
      end else if (bus.start) begin
         r_a   <= bus.a;
         r_idx <= 2'd0;
         r_c   <= carry_in(bus.a[WIDTH-1], TWOS);
         r_mag <= 3'b000;
         r_ovf <= 1'b0;
      end else if (r_state == CONV) begin
         r_mag[r_idx] <= w_fa_sum;
         r_c          <= w_fa_co;
         if (w_last) begin
            r_sum <= {r_a[WIDTH-1], w_fa_sum, r_mag[1:0]};
`ifdef COMPLEMENT2_EN
            r_ovf <= w_neg & w_fa_co;
`else
            r_ovf <= 1'b0;
`endif
         end else begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   assign bus.sum = r_sum;
   assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_complement_decode_4bits.sv
// Directed bench for complement_decode_4bits; expected values follow the
// build selected by COMPLEMENT2_EN.
module tb_complement_decode_4bits;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   complement_decode_4bits_if u_if ();

   complement_decode_4bits dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required<100000", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] e_sum, input logic e_busy,
                          input logic e_fin, input logic e_ovf);
      chk({tag, ".sum"},    u_if.sum,              e_sum);
      chk({tag, ".busy"},   {3'b000, u_if.busy},   {3'b000, e_busy});
      chk({tag, ".finish"}, {3'b000, u_if.finish}, {3'b000, e_fin});
      chk({tag, ".ovf"},    {3'b000, u_if.ovf},    {3'b000, e_ovf});
   endtask

   // Pulse start with operand v, expect 3 busy cycles then finish with result.
   task automatic run_conv(input string tag, input logic [3:0] v, input logic [3:0] prev_sum,
                           input logic [3:0] e_sum, input logic e_ovf);
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.a     = v;
      @(negedge clk);
      u_if.start = 1'b0;
      chk_out({tag, ".c0"}, prev_sum, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out({tag, ".c1"}, prev_sum, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out({tag, ".c2"}, prev_sum, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out({tag, ".done"}, e_sum, 1'b0, 1'b1, e_ovf);
   endtask

   logic [3:0] last_sum;
   logic       last_ovf;

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b1;
      u_if.start = 1'b0;
      u_if.a     = 4'b0000;

      // Reset state
      #12;
      chk_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Idle hold with changing operand
      for (int i = 0; i < 4; i++) begin
         u_if.a = 4'(i * 5 + 3);
         @(negedge clk);
         chk_out("idle_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
      end

      // Positive operand
      run_conv("pos0101", 4'b0101, 4'b0000, 4'b0101, 1'b0);
      run_conv("pos0111", 4'b0111, 4'b0101, 4'b0111, 1'b0);

`ifdef COMPLEMENT2_EN
      run_conv("neg1101", 4'b1101, 4'b0111, 4'b1011, 1'b0);
      run_conv("neg1000", 4'b1000, 4'b1011, 4'b1000, 1'b1);
      run_conv("neg1111", 4'b1111, 4'b1000, 4'b1001, 1'b0);
      run_conv("neg1000b", 4'b1000, 4'b1001, 4'b1000, 1'b1);
      last_sum = 4'b1000;
      last_ovf = 1'b1;
`else
      run_conv("neg1100", 4'b1100, 4'b0111, 4'b1011, 1'b0);
      run_conv("neg1111", 4'b1111, 4'b1011, 4'b1000, 1'b0);
      run_conv("neg1010", 4'b1010, 4'b1000, 4'b1101, 1'b0);
      last_sum = 4'b1101;
      last_ovf = 1'b0;
`endif

      // Hold in DONE while operand wanders
      for (int i = 0; i < 10; i++) begin
         u_if.a = 4'($urandom_range(0, 15));
         @(negedge clk);
         chk_out("done_hold", last_sum, 1'b0, 1'b1, last_ovf);
      end

      // Restart: second start one cycle after the first
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.a     = 4'b1110;
      @(negedge clk);
      u_if.a     = 4'b0011;
      @(negedge clk);
      u_if.start = 1'b0;
      chk_out("restart.c0", last_sum, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("restart.c1", last_sum, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("restart.c2", last_sum, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("restart.done", 4'b0011, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-conversion
      @(negedge clk);
      u_if.start = 1'b1;
      u_if.a     = 4'b1101;
      @(negedge clk);
      u_if.start = 1'b0;
      @(negedge clk);
      chk_out("rstmid.pre", 4'b0011, 1'b1, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk_out("rstmid.async", 4'b0000, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_out("rstmid.nofin", 4'b0000, 1'b0, 1'b0, 1'b0);
      end
      run_conv("postrst0110", 4'b0110, 4'b0000, 4'b0110, 1'b0);

      // Reset has priority over start
      @(negedge clk);
      rst        = 1'b1;
      u_if.start = 1'b1;
      u_if.a     = 4'b0101;
      @(negedge clk);
      chk_out("rst_prio", 4'b0000, 1'b0, 1'b0, 1'b0);
      u_if.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_out("rst_prio.idle", 4'b0000, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
